// File: rtl/video_source_ctrl.sv
// video_source_ctrl: frame-aligned test-pattern / live-video source select with a debounced user button.
// Optional sync watchdog (LOST/RELOCK states) is compiled in when VIDEO_SRC_CTRL_WATCHDOG_EN is defined.
module video_source_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_TIMEOUT    = 1024,
  parameter int LOCK_FRAMES     = 4
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iPixelSync,
  input  logic       iButton,
  input  logic       iForceTest,
  output logic       oTestData,
  output logic       oInputLost,
  output logic [1:0] oState
);

  // state  | meaning
  // LIVE   | live video selected
  // TEST   | test pattern selected
  // LOST   | no frame sync seen, test pattern forced
  // RELOCK | sync returned, counting LOCK_FRAMES pulses before trusting it
  localparam logic [1:0] ST_LIVE = 2'd0;
  localparam logic [1:0] ST_TEST = 2'd1;
  localparam int DbW = $clog2(DEBOUNCE_CYCLES + 1);

  if (DEBOUNCE_CYCLES < 1 || SYNC_TIMEOUT < 2 || LOCK_FRAMES < 1) begin : g_cfg_check
    $error("video_source_ctrl: invalid parameter set");
  end

`ifdef VIDEO_SRC_CTRL_WATCHDOG_EN
  localparam logic [1:0] ST_LOST   = 2'd2;
  localparam logic [1:0] ST_RELOCK = 2'd3;
  localparam logic [1:0] ST_RESET  = ST_LOST;
  localparam int WdW = $clog2(SYNC_TIMEOUT + 1);
  localparam int LkW = $clog2(LOCK_FRAMES + 1);
`else
  localparam logic [1:0] ST_RESET  = ST_LIVE;
`endif

  logic           btnMeta_q, btnSync_q;
  logic           dbLevel_q, dbLevel_d, dbLevelDly_q;
  logic [DbW-1:0] dbCnt_q, dbCnt_d, dbCntInc;
  logic           userReq_q, userReq_d;
  logic           desired;
  logic [1:0]     state_q, state_d;
  logic           testData_q;

  assign dbCntInc = dbCnt_q + 1'b1;

  // Counter only runs while the synchronized level disagrees with the accepted one.
  always_comb begin
    dbCnt_d   = '0;
    dbLevel_d = dbLevel_q;
    if (btnSync_q != dbLevel_q) begin
      if (dbCntInc == DbW'(DEBOUNCE_CYCLES)) begin
        dbLevel_d = btnSync_q;
      end else begin
        dbCnt_d = dbCntInc;
      end
    end
  end

  assign userReq_d = userReq_q ^ (dbLevel_q & ~dbLevelDly_q);
  assign desired   = userReq_q | iForceTest;

`ifdef VIDEO_SRC_CTRL_WATCHDOG_EN
  logic [WdW-1:0] wdCnt_q, wdCnt_d;
  logic [LkW-1:0] lockCnt_q, lockCnt_d, lockCntInc;
  logic           timeout;
  logic           inputLost_q;

  always_comb begin
    if (iPixelSync) begin
      wdCnt_d = '0;
    end else if (wdCnt_q == WdW'(SYNC_TIMEOUT)) begin
      wdCnt_d = wdCnt_q;
    end else begin
      wdCnt_d = wdCnt_q + 1'b1;
    end
  end

  // A pulse in the same cycle always wins over the timeout.
  assign timeout    = ~iPixelSync & (wdCnt_q == WdW'(SYNC_TIMEOUT - 1));
  assign lockCntInc = lockCnt_q + 1'b1;
`endif

  always_comb begin
    state_d = state_q;
`ifdef VIDEO_SRC_CTRL_WATCHDOG_EN
    lockCnt_d = lockCnt_q;
`endif
    case (state_q)
      ST_LIVE: if (iPixelSync && desired)  state_d = ST_TEST;
      ST_TEST: if (iPixelSync && !desired) state_d = ST_LIVE;
`ifdef VIDEO_SRC_CTRL_WATCHDOG_EN
      ST_LOST: begin
        if (iPixelSync) begin
          state_d   = ST_RELOCK;
          lockCnt_d = '0;
        end
      end
      ST_RELOCK: begin
        if (iPixelSync) begin
          lockCnt_d = lockCntInc;
          if (lockCntInc == LkW'(LOCK_FRAMES)) begin
            state_d = desired ? ST_TEST : ST_LIVE;
          end
        end
      end
`endif
      default: state_d = ST_RESET;
    endcase
`ifdef VIDEO_SRC_CTRL_WATCHDOG_EN
    if (timeout) begin
      state_d = ST_LOST;
    end
`endif
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      btnMeta_q    <= 1'b0;
      btnSync_q    <= 1'b0;
      dbLevel_q    <= 1'b0;
      dbLevelDly_q <= 1'b0;
      dbCnt_q      <= '0;
      userReq_q    <= 1'b0;
      state_q      <= ST_RESET;
      testData_q   <= (ST_RESET != ST_LIVE);
    end else begin
      btnMeta_q    <= iButton;
      btnSync_q    <= btnMeta_q;
      dbLevel_q    <= dbLevel_d;
      dbLevelDly_q <= dbLevel_q;
      dbCnt_q      <= dbCnt_d;
      userReq_q    <= userReq_d;
      state_q      <= state_d;
      testData_q   <= (state_d != ST_LIVE);
    end
  end

`ifdef VIDEO_SRC_CTRL_WATCHDOG_EN
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      wdCnt_q     <= '0;
      lockCnt_q   <= '0;
      inputLost_q <= 1'b1;
    end else begin
      wdCnt_q     <= wdCnt_d;
      lockCnt_q   <= lockCnt_d;
      inputLost_q <= (state_d == ST_LOST);
    end
  end

  assign oInputLost = inputLost_q;
`else
  assign oInputLost = 1'b0;
`endif

  assign oTestData = testData_q;
  assign oState    = state_q;

endmodule

// File: tb/tb_video_source_ctrl.sv
// Bench for video_source_ctrl: directed frame/button/force/watchdog scenarios plus random stimulus,
// all checked every cycle against a cycle-count based behavioural model.
module tb_video_source_ctrl;

  localparam int DEB = 16;
  localparam int TMO = 1024;
  localparam int LCK = 4;
`ifdef VIDEO_SRC_CTRL_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  localparam logic [7:0] RST_CODE = WD ? 8'd11 : 8'd0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps  = 1'b0;
  logic       btn = 1'b0;
  logic       frc = 1'b0;
  logic       oTestData, oInputLost;
  logic [1:0] oState;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  video_source_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .SYNC_TIMEOUT   (TMO),
    .LOCK_FRAMES    (LCK)
  ) dut (
    .iClk      (clk),
    .iRst      (rst),
    .iPixelSync(ps),
    .iButton   (btn),
    .iForceTest(frc),
    .oTestData (oTestData),
    .oInputLost(oInputLost),
    .oState    (oState)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] dut_code();
    return {4'b0, oState, oInputLost, oTestData};
  endfunction

  // Behavioural model: button pipeline as sample history, watchdog as cycle distance from last pulse.
  int m_state, m_run, m_lock, m_cyc, m_last;
  bit m_user, m_level, m_rose, m_r1, m_r2;

  function automatic logic [7:0] m_code();
    return {4'b0, 2'(m_state), 1'(m_state == 2), 1'(m_state != 0)};
  endfunction

  task automatic m_reset();
    m_state = WD ? 2 : 0;
    m_user  = 0; m_level = 0; m_rose = 0; m_r1 = 0; m_r2 = 0;
    m_run   = 0; m_lock  = 0;
    m_last  = m_cyc;
  endtask

  task automatic m_step(input bit p, input bit b, input bit f);
    bit desired, toggle, tmo, s;
    int nxt;
    m_cyc++;
    desired = m_user | f;
    tmo     = WD && !p && (m_cyc - m_last == TMO);
    nxt     = m_state;
    case (m_state)
      0: if (p && desired)  nxt = 1;
      1: if (p && !desired) nxt = 0;
      2: if (p) begin nxt = 3; m_lock = 0; end
      default: if (p) begin
        m_lock++;
        if (m_lock == LCK) nxt = desired ? 1 : 0;
      end
    endcase
    if (tmo) nxt = 2;
    m_state = nxt;
    if (p) m_last = m_cyc;
    toggle = m_rose;
    m_rose = 0;
    s      = m_r2;
    if (s != m_level) begin
      m_run++;
      if (m_run == DEB) begin
        m_level = s;
        m_run   = 0;
        m_rose  = s;
      end
    end else begin
      m_run = 0;
    end
    if (toggle) m_user = ~m_user;
    m_r2 = m_r1;
    m_r1 = b;
  endtask

  initial begin
    m_cyc = 0;
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else     m_step(ps, btn, frc);
    end
  end

  initial begin
    @(negedge clk);
    forever begin
      chk("outputs_vs_model", dut_code(), m_code());
      @(negedge clk);
    end
  end

  task automatic cyc(input logic p, input logic b, input logic f);
    ps = p; btn = b; frc = f;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ps = 1'b0; btn = 1'b0; frc = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("reset_state", dut_code(), RST_CODE);
    rst = 1'b0;
  endtask

  function automatic bit s4_pulse(input int k);
    return k inside {800, 1600, 2400, 3200, 4000, 5600, 6400, 7200, 8000, 8800,
                     9824, 11000, 11800, 12800, 13600, 14400, 15200, 16000};
  endfunction

  initial begin
    int gap, hold, r;
    bit p, b, f;

    // Bounce rejection: chatter shorter than the debounce window must never toggle the request.
    do_reset();
    for (int k = 0; k < 1700; k++) begin
      b = (k >= 100 && k < 200) ? (((k - 100) / 5) % 2 == 0) : 1'b0;
      cyc((k == 800) || (k == 1600), b, 1'b0);
`ifdef VIDEO_SRC_CTRL_WATCHDOG_EN
      if (k == 1600) chk("bounce_state", 8'(oState), 8'd3);
`else
      if (k == 800)  chk("bounce_state_800", 8'(oState), 8'd0);
      if (k == 1600) chk("bounce_state_1600", 8'(oState), 8'd0);
`endif
    end

    // Button press switches only at the next frame pulse.
    do_reset();
    for (int k = 0; k < 1700; k++) begin
`ifndef VIDEO_SRC_CTRL_WATCHDOG_EN
      if (k == 500) chk("btn_mid_frame", 8'(oTestData), 8'd0);
      if (k == 800) chk("btn_before_pulse", 8'(oTestData), 8'd0);
`endif
      cyc((k == 800) || (k == 1600), (k >= 100 && k < 140), 1'b0);
`ifndef VIDEO_SRC_CTRL_WATCHDOG_EN
      if (k == 800) chk("btn_after_pulse", 8'(oTestData), 8'd1);
`endif
    end

    // Force override on and off, each aligned to a pulse.
    do_reset();
    for (int k = 0; k < 1700; k++) begin
      cyc((k == 800) || (k == 1600), 1'b0, (k >= 50 && k < 900));
`ifndef VIDEO_SRC_CTRL_WATCHDOG_EN
      if (k == 799)  chk("force_before_pulse", 8'(oState), 8'd0);
      if (k == 800)  chk("force_to_test", 8'(oState), 8'd1);
      if (k == 1599) chk("force_held_test", 8'(oState), 8'd1);
      if (k == 1600) chk("force_back_live", 8'(oState), 8'd0);
`endif
    end

    // Watchdog timeline: relock, loss, relock, pulse-at-timeout, reset mid-RELOCK.
    do_reset();
    for (int k = 0; k < 16100; k++) begin
      if (k == 12000) begin
        rst = 1'b1;
        #1;
        chk("async_reset_mid_relock", dut_code(), RST_CODE);
      end
      if (k == 12003) rst = 1'b0;
      cyc(s4_pulse(k), 1'b0, 1'b0);
      if (k == 5023) chk("no_loss_before_timeout", 8'(oInputLost), 8'd0);
      if (k == 9824) chk("pulse_at_timeout", dut_code(), 8'd0);
`ifdef VIDEO_SRC_CTRL_WATCHDOG_EN
      if (k == 800)   chk("relock_entry", 8'(oState), 8'd3);
      if (k == 3200)  chk("relock_after_3", 8'(oState), 8'd3);
      if (k == 4000)  chk("relock_done", 8'(oState), 8'd0);
      if (k == 5024)  chk("loss_at_t1025", dut_code(), 8'd11);
      if (k == 5600)  chk("relock_again", 8'(oState), 8'd3);
      if (k == 8000)  chk("relock_again_3", 8'(oState), 8'd3);
      if (k == 8800)  chk("relock_again_done", 8'(oState), 8'd0);
      if (k == 15200) chk("post_reset_relock_3", 8'(oState), 8'd3);
      if (k == 16000) chk("post_reset_relock_done", 8'(oState), 8'd0);
`else
      if (k == 5024)  chk("no_watchdog_loss", dut_code(), 8'd0);
`endif
    end

    // Random stimulus: jittered frame gaps (some straddling the timeout), held button levels, force flips.
    do_reset();
    gap = $urandom_range(150, 1300);
    hold = 0; b = 1'b0; f = 1'b0;
    for (int k = 0; k < 30000; k++) begin
      p = 1'b0;
      if (gap == 0) begin
        p = 1'b1;
        r = $urandom_range(0, 7);
        gap = (r == 0) ? TMO - 1 : (r == 1) ? TMO : $urandom_range(150, 1300);
      end else begin
        gap--;
      end
      if (hold == 0) begin
        b = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 40);
      end else begin
        hold--;
      end
      if ($urandom_range(0, 599) == 0) f = ~f;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 9999) == 0) rst = 1'b1;
      cyc(p, b, f);
    end

    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
